// File: rtl/im_fetch_ram.sv
// im_fetch_ram: parametrised instruction RAM with boot-load port, LOAD/RUN mode and fetch handshake
// Ports: i_clk/i_rst_n clock and async active-low reset; i_boot_done ends LOAD;
//   i_ld_we/i_ld_addr/i_ld_data loader writes; i_fetch_req/i_fetch_addr/i_stall fetch side;
//   o_fetch_ready, o_instr_valid, o_instr, o_fault fetch results; o_run_mode, o_ld_count, o_ld_err status.
module im_fetch_ram #(
    parameter int                ADDR_W     = 11,
    parameter int                DEPTH      = 1536,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] FILL_INSTR = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_boot_done,
    input  logic                i_ld_we,
    input  logic [ADDR_W-1:0]   i_ld_addr,
    input  logic [DATA_W-1:0]   i_ld_data,
    input  logic                i_fetch_req,
    input  logic [ADDR_W+1:0]   i_fetch_addr,
    input  logic                i_stall,
    output logic                o_fetch_ready,
    output logic                o_instr_valid,
    output logic [DATA_W-1:0]   o_instr,
    output logic                o_fault,
    output logic                o_run_mode,
    output logic [ADDR_W:0]     o_ld_count,
    output logic                o_ld_err
);
    localparam logic       LOAD = 1'b0;
    localparam logic       RUN  = 1'b1;
    localparam logic [ADDR_W:0] LIM = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_state;
    logic              r_valid;
    logic              r_fault;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W:0]   r_ld_count;
    logic              r_ld_err;
    logic [ADDR_W-1:0] w_idx;
    logic              w_fault;
    logic              w_ld_ok;
    logic              w_ready;
    logic              w_accept;

    assign w_idx    = i_fetch_addr[ADDR_W+1:2];
    assign w_fault  = (i_fetch_addr[1:0] != 2'b00) | ({1'b0, w_idx} >= LIM);
    assign w_ld_ok  = (r_state == LOAD) & i_ld_we & ({1'b0, i_ld_addr} < LIM);
    assign w_ready  = (r_state == RUN) & ~(r_valid & i_stall);
    assign w_accept = i_fetch_req & w_ready;

    // RAM has no reset so contents survive a reset; writes only happen in LOAD, reads only in RUN
    always_ff @(posedge i_clk) begin
        if (w_ld_ok) r_mem[i_ld_addr] <= i_ld_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= LOAD;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_instr    <= FILL_INSTR;
            r_ld_count <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            if (r_state == LOAD && i_boot_done) r_state <= RUN;
            if (w_ld_ok && !(&r_ld_count)) r_ld_count <= r_ld_count + 1'b1;
            if (i_ld_we && (r_state == RUN || !w_ld_ok)) r_ld_err <= 1'b1;
            // faulting fetches never touch the RAM
            if (w_accept) begin
                r_valid <= 1'b1;
                r_fault <= w_fault;
                r_instr <= w_fault ? FILL_INSTR : r_mem[w_idx];
            end else if (!(r_valid && i_stall)) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_fetch_ready = w_ready;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_instr;
    assign o_fault       = r_fault;
    assign o_run_mode    = r_state;
    assign o_ld_count    = r_ld_count;
    assign o_ld_err      = r_ld_err;
endmodule

// File: tb/tb_im_fetch_ram.sv
// tb_im_fetch_ram: directed self-checking bench for im_fetch_ram
module tb_im_fetch_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_done = 1'b0;
    logic        ld_we = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        fetch_req = 1'b0;
    logic [12:0] fetch_addr = '0;
    logic        stall = 1'b0;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        fault;
    logic        run_mode;
    logic [11:0] ld_count;
    logic        ld_err;
    int          n_chk = 0;
    int          n_pass = 0;

    im_fetch_ram dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_boot_done(boot_done), .i_ld_we(ld_we),
        .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_fetch_req(fetch_req),
        .i_fetch_addr(fetch_addr), .i_stall(stall), .o_fetch_ready(fetch_ready),
        .o_instr_valid(instr_valid), .o_instr(instr), .o_fault(fault),
        .o_run_mode(run_mode), .o_ld_count(ld_count), .o_ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [10:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic boot();
        boot_done = 1'b1;
        tick();
        boot_done = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", ld_count, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_mode", run_mode, 0);
        chk("rst_ready", fetch_ready, 0);
        tick();
        rst_n = 1'b1;
        // 1: boot load
        load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
        load(1535, 32'hCAFE_F00D);
        boot();
        chk("t1_count", ld_count, 5);
        chk("t1_mode", run_mode, 1);
        chk("t1_err", ld_err, 0);
        chk("t1_ready", fetch_ready, 1);
        // 2: back-to-back fetches
        fetch_req = 1'b1; fetch_addr = 13'h0;
        tick(); chk("t2_v0", instr_valid, 1); chk("t2_i0", instr, 32'h11);
        fetch_addr = 13'h4;
        tick(); chk("t2_v1", instr_valid, 1); chk("t2_i1", instr, 32'h22);
        fetch_addr = 13'h8;
        tick(); chk("t2_v2", instr_valid, 1); chk("t2_i2", instr, 32'h33);
        fetch_addr = 13'h17FC;
        tick(); chk("t2_last", instr, 32'hCAFE_F00D); chk("t2_last_f", fault, 0);
        fetch_req = 1'b0;
        tick(); chk("t2_idle_v", instr_valid, 0); chk("t2_idle_i", instr, 32'hCAFE_F00D);
        // 3: faults and RUN-mode load attempt
        fetch_req = 1'b1; fetch_addr = 13'h2;
        tick(); chk("t3_mis_f", fault, 1); chk("t3_mis_i", instr, 0); chk("t3_mis_v", instr_valid, 1);
        fetch_addr = 13'h1800;
        tick(); chk("t3_oor_f", fault, 1); chk("t3_oor_v", instr_valid, 1);
        fetch_req = 1'b0;
        load(1, 32'hDEAD_BEEF);
        chk("t3_err", ld_err, 1);
        chk("t3_count", ld_count, 5);
        fetch_req = 1'b1; fetch_addr = 13'h4;
        tick(); chk("t3_old", instr, 32'h22); chk("t3_old_f", fault, 0);
        // 4: stall holds output and blocks acceptance
        stall = 1'b1; fetch_addr = 13'h8;
        #1 chk("t4_ready0", fetch_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_i", instr, 32'h22);
            chk("t4_hold_v", instr_valid, 1);
            chk("t4_hold_r", fetch_ready, 0);
        end
        stall = 1'b0;
        #1 chk("t4_ready1", fetch_ready, 1);
        tick(); chk("t4_next", instr, 32'h33); chk("t4_next_v", instr_valid, 1);
        // 5: async reset mid-cycle, contents kept
        fetch_addr = 13'h0;
        #2 rst_n = 1'b0;
        #1 chk("t5_valid", instr_valid, 0);
        chk("t5_mode", run_mode, 0);
        chk("t5_count", ld_count, 0);
        tick();
        rst_n = 1'b1;
        boot();
        chk("t5_nov", instr_valid, 0);
        tick(); chk("t5_kept", instr, 32'h11); chk("t5_kept_v", instr_valid, 1);
        // 6: LOAD ignores fetches, out-of-range load flags error
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 13'h0;
        #1 chk("t6_ready", fetch_ready, 0);
        tick(); chk("t6_nov", instr_valid, 0);
        load(11'd1536, 32'h55);
        chk("t6_err", ld_err, 1);
        chk("t6_count", ld_count, 0);
        chk("t6_nov2", instr_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
